// File: rtl/interrupt_sequencer.sv
// interrupt_sequencer
// Control core of an 8259-style programmable interrupt controller:
//   - latches the IR lines into the IRR (edge or level triggered)
//   - resolves rotating, fully nested priority against the ISR and raises INT
//   - runs the two-pulse INTA acknowledge sequence and emits the vector
//   - handles specific / non-specific EOI, priority rotation and set-priority
// Optional feature: define AUTO_EOI_EN to add the auto_eoi input. When it is
// high at the second INTA pulse, the acknowledged ISR bit is cleared there.
//
// INTA handshake: inta_n is sampled on clk and every 1->0 transition is one
// acknowledge pulse. Pulses only advance the sequence while int_req is up
// (WAIT1) or between the two pulses (WAIT2); pulses seen in IDLE are ignored.
// vector_valid is a one-cycle strobe with no back-pressure; vector holds its
// last value until the next completed acknowledge.
// fsm_state exposes the sequencer state: 0 = IDLE, 1 = WAIT1, 2 = WAIT2.

module interrupt_sequencer #(
    parameter logic [2:0] RESET_LOWEST = 3'd7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       level_mode,
    input  logic [4:0] vector_base,
    input  logic       inta_n,
    input  logic       eoi_valid,
    input  logic       eoi_specific,
    input  logic       eoi_rotate,
    input  logic [2:0] eoi_level,
    input  logic       setpri_valid,
    input  logic [2:0] setpri_level,
`ifdef AUTO_EOI_EN
    input  logic       auto_eoi,
`endif
    output logic       int_req,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic [7:0] irr_q,
    output logic [7:0] isr_q,
    output logic [1:0] fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT1 = 2'd1,
        WAIT2 = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] prev_ir;
    logic       inta_prev;
    logic [2:0] lowest;
    logic [2:0] level_q;

    logic       inta_fall;
    logic [3:0] req_pick;
    logic [3:0] blk_pick;
    logic [3:0] eoi_pick;
    logic [2:0] req_rank;
    logic [2:0] blk_rank;
    logic       cand_valid;
    logic [2:0] cand_level;
    logic       ack1_take;
    logic       ack2;
    logic [7:0] ack_mask;
    logic [7:0] eoi_mask;
    logic [7:0] auto_mask;
    logic       auto_rotate;
    logic [2:0] lowest_next;

    // Returns {found, level} of the highest-priority set bit, where the level
    // just above 'low' (wrapping) has top priority.
    function automatic logic [3:0] pick_highest(input logic [7:0] bits,
                                                input logic [2:0] low);
        logic [3:0] r;
        logic [2:0] lvl;
        r = 4'd0;
        // Walk from lowest to highest priority so the last hit wins.
        for (int p = 7; p >= 0; p--) begin
            lvl = low + 3'd1 + 3'(p);
            if (bits[lvl]) begin
                r = {1'b1, lvl};
            end
        end
        return r;
    endfunction

    assign fsm_state = state;
    assign inta_fall = inta_prev & ~inta_n;

    // Priority resolution on the registered IRR/ISR/lowest view.
    always_comb begin
        // Masked ISR bits do not block lower levels (special-mask behaviour).
        req_pick   = pick_highest(irr_q & ~imr, lowest);
        blk_pick   = pick_highest(isr_q & ~imr, lowest);
        // Non-specific EOI targets the highest set ISR bit regardless of mask.
        eoi_pick   = pick_highest(isr_q, lowest);
        // Rank 0 is the highest priority position.
        req_rank   = req_pick[2:0] - lowest - 3'd1;
        blk_rank   = blk_pick[2:0] - lowest - 3'd1;
        cand_valid = req_pick[3] & (~blk_pick[3] | (req_rank < blk_rank));
        cand_level = req_pick[2:0];
    end

    // Acknowledge and EOI decode shared by the IRR, ISR and FSM registers.
    always_comb begin
        ack1_take = (state == WAIT1) && inta_fall && cand_valid;
        ack2      = (state == WAIT2) && inta_fall;
        ack_mask  = 8'd0;
        if (ack1_take) begin
            ack_mask = 8'd1 << cand_level;
        end
        eoi_mask = 8'd0;
        if (eoi_valid) begin
            if (eoi_specific) begin
                eoi_mask = 8'd1 << eoi_level;
            end else if (eoi_pick[3]) begin
                eoi_mask = 8'd1 << eoi_pick[2:0];
            end
        end
    end

`ifdef AUTO_EOI_EN
    logic ack_real;

    // Auto-EOI releases the level just vectored, unless the cycle was spurious.
    always_comb begin
        auto_mask   = 8'd0;
        auto_rotate = 1'b0;
        if (ack2 && auto_eoi && ack_real) begin
            auto_mask   = 8'd1 << level_q;
            auto_rotate = eoi_rotate;
        end
    end
`else
    // Without auto-EOI, ISR bits are released only by EOI commands.
    always_comb begin
        auto_mask   = 8'd0;
        auto_rotate = 1'b0;
    end
`endif

    // Next lowest-priority level: EOI rotation, then auto rotation, setpri last.
    always_comb begin
        lowest_next = lowest;
        if (eoi_valid && eoi_rotate) begin
            if (eoi_specific) begin
                lowest_next = eoi_level;
            end else if (eoi_pick[3]) begin
                lowest_next = eoi_pick[2:0];
            end
        end
        if (auto_rotate) begin
            lowest_next = level_q;
        end
        if (setpri_valid) begin
            lowest_next = setpri_level;
        end
    end

    // IRR capture: edge or level sampling, with the acknowledged bit cleared.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_ir <= 8'd0;
            irr_q   <= 8'd0;
        end else begin
            prev_ir <= ir;
            if (level_mode) begin
                irr_q <= ir & ~ack_mask;
            end else begin
                irr_q <= (irr_q & ~ack_mask) | (ir & ~prev_ir);
            end
        end
    end

    // ISR and rotation state; an ACK1 set overrides a same-cycle EOI clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            isr_q  <= 8'd0;
            lowest <= RESET_LOWEST;
        end else begin
            isr_q  <= (isr_q & ~eoi_mask & ~auto_mask) | ack_mask;
            lowest <= lowest_next;
        end
    end

    // Acknowledge sequencer: INT request, two INTA pulses, vector strobe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            inta_prev    <= 1'b1;
            int_req      <= 1'b0;
            level_q      <= 3'd0;
            vector       <= 8'd0;
            vector_valid <= 1'b0;
`ifdef AUTO_EOI_EN
            ack_real     <= 1'b0;
`endif
        end else begin
            inta_prev    <= inta_n;
            vector_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cand_valid) begin
                        int_req <= 1'b1;
                        state   <= WAIT1;
                    end
                end
                WAIT1: begin
                    // int_req stays up even if the candidate has vanished.
                    if (inta_fall) begin
                        int_req <= 1'b0;
                        state   <= WAIT2;
                        // No candidate left at ACK1: spurious, report level 7.
                        level_q <= cand_valid ? cand_level : 3'd7;
`ifdef AUTO_EOI_EN
                        ack_real <= cand_valid;
`endif
                    end
                end
                WAIT2: begin
                    if (inta_fall) begin
                        vector       <= {vector_base, level_q};
                        vector_valid <= 1'b1;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Testbench for interrupt_sequencer: directed scenarios followed by random
// operations checked against a transaction-level priority model.
// Define AUTO_EOI_EN to also exercise the auto-EOI port.

module tb_interrupt_sequencer;

    logic       clk;
    logic       reset_n;
    logic [7:0] ir;
    logic [7:0] imr;
    logic       level_mode;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       eoi_valid;
    logic       eoi_specific;
    logic       eoi_rotate;
    logic [2:0] eoi_level;
    logic       setpri_valid;
    logic [2:0] setpri_level;
`ifdef AUTO_EOI_EN
    logic       auto_eoi;
`endif
    logic       int_req;
    logic [7:0] vector;
    logic       vector_valid;
    logic [7:0] irr_q;
    logic [7:0] isr_q;
    logic [1:0] fsm_state;

    int checks = 0;
    int passed = 0;

    // Reference model state
    logic [7:0] m_irr;
    logic [7:0] m_isr;
    logic [7:0] m_imr;
    int         m_lowest;
    bit         m_pending;

    interrupt_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ir           (ir),
        .imr          (imr),
        .level_mode   (level_mode),
        .vector_base  (vector_base),
        .inta_n       (inta_n),
        .eoi_valid    (eoi_valid),
        .eoi_specific (eoi_specific),
        .eoi_rotate   (eoi_rotate),
        .eoi_level    (eoi_level),
        .setpri_valid (setpri_valid),
        .setpri_level (setpri_level),
`ifdef AUTO_EOI_EN
        .auto_eoi     (auto_eoi),
`endif
        .int_req      (int_req),
        .vector       (vector),
        .vector_valid (vector_valid),
        .irr_q        (irr_q),
        .isr_q        (isr_q),
        .fsm_state    (fsm_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time bound
    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "time limit");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_ir(input logic [7:0] bits);
        ir = bits;
        step(1);
        ir = 8'h00;
    endtask

    task automatic send_eoi(input bit specific, input bit rotate, input logic [2:0] lvl);
        eoi_valid    = 1'b1;
        eoi_specific = specific;
        eoi_rotate   = rotate;
        eoi_level    = lvl;
        step(1);
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
    endtask

    task automatic set_pri(input logic [2:0] lvl);
        setpri_valid = 1'b1;
        setpri_level = lvl;
        step(1);
        setpri_valid = 1'b0;
    endtask

    // Two INTA pulses; optional specific EOI issued in the ACK1 cycle.
    task automatic inta_seq(input logic [4:0] base, input logic [2:0] exp_lvl,
                            input bit eoi_at_ack1, input logic [2:0] eoi_lvl,
                            input string tag);
        logic [7:0] exp_vec;
        exp_vec     = {base, exp_lvl};
        vector_base = base;
        inta_n      = 1'b0;
        if (eoi_at_ack1) begin
            eoi_valid    = 1'b1;
            eoi_specific = 1'b1;
            eoi_rotate   = 1'b0;
            eoi_level    = eoi_lvl;
        end
        step(1);
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        inta_n       = 1'b1;
        check({tag, "_intreq_after_ack1"}, int_req, 1'b0);
        step(1);
        inta_n = 1'b0;
        step(1);
        inta_n = 1'b1;
        check({tag, "_vvalid"}, vector_valid, 1'b1);
        check({tag, "_vector"}, vector, exp_vec);
        step(1);
        check({tag, "_vvalid_drop"}, vector_valid, 1'b0);
    endtask

    // Model: priority rank 0 is the level just above the lowest one.
    function automatic int rank(input int lvl);
        return (lvl - m_lowest + 15) % 8;
    endfunction

    function automatic int best_of(input logic [7:0] v);
        int b;
        b = -1;
        for (int l = 0; l < 8; l++) begin
            if (v[l] && (b < 0 || rank(l) < rank(b))) b = l;
        end
        return b;
    endfunction

    function automatic int model_cand();
        int r;
        int s;
        r = best_of(m_irr & ~m_imr);
        if (r < 0) return -1;
        s = best_of(m_isr & ~m_imr);
        if (s >= 0 && rank(s) <= rank(r)) return -1;
        return r;
    endfunction

    initial begin
        int c;
        int op;
        logic [7:0] bits;
        logic [2:0] lvl;
        logic [4:0] base;
        bit spec;
        bit rot;

        reset_n      = 1'b0;
        ir           = 8'h00;
        imr          = 8'h00;
        level_mode   = 1'b0;
        vector_base  = 5'h00;
        inta_n       = 1'b1;
        eoi_valid    = 1'b0;
        eoi_specific = 1'b0;
        eoi_rotate   = 1'b0;
        eoi_level    = 3'd0;
        setpri_valid = 1'b0;
        setpri_level = 3'd0;
`ifdef AUTO_EOI_EN
        auto_eoi     = 1'b0;
`endif
        step(3);
        check("rst_intreq", int_req, 1'b0);
        check("rst_vector", vector, 8'h00);
        check("rst_vvalid", vector_valid, 1'b0);
        check("rst_irr", irr_q, 8'h00);
        check("rst_isr", isr_q, 8'h00);
        check("rst_state", fsm_state, 2'd0);
        reset_n = 1'b1;
        step(2);

        // Edge mode, IR3 acknowledged with base 0x08
        pulse_ir(8'h08);
        step(3);
        check("t1_intreq", int_req, 1'b1);
        check("t1_irr", irr_q, 8'h08);
        inta_seq(5'h08, 3'd3, 1'b0, 3'd0, "t1");
        check("t1_isr", isr_q, 8'h08);
        check("t1_irr_clr", irr_q, 8'h00);

        // Nesting: IR5 blocked by IR2 in service, IR1 outranks it
        send_eoi(1'b1, 1'b0, 3'd3);
        check("t2_isr_clear", isr_q, 8'h00);
        pulse_ir(8'h04);
        step(3);
        inta_seq(5'h08, 3'd2, 1'b0, 3'd0, "t2a");
        check("t2_isr4", isr_q, 8'h04);
        pulse_ir(8'h20);
        step(3);
        check("t2_ir5_blocked", int_req, 1'b0);
        check("t2_irr20", irr_q, 8'h20);
        pulse_ir(8'h02);
        step(3);
        check("t2_ir1_intreq", int_req, 1'b1);
        inta_seq(5'h08, 3'd1, 1'b0, 3'd0, "t2b");
        check("t2_isr6", isr_q, 8'h06);
        send_eoi(1'b0, 1'b0, 3'd0);
        check("t2_nseoi1", isr_q, 8'h04);
        send_eoi(1'b0, 1'b0, 3'd0);
        step(3);
        check("t2_ir5_now", int_req, 1'b1);
        inta_seq(5'h08, 3'd5, 1'b0, 3'd0, "t2c");
        send_eoi(1'b0, 1'b0, 3'd0);
        check("t2_clean_isr", isr_q, 8'h00);
        check("t2_clean_irr", irr_q, 8'h00);

        // Level mode request withdrawn before ACK1: spurious vector
        level_mode = 1'b1;
        ir = 8'h04;
        step(3);
        check("t3_intreq", int_req, 1'b1);
        check("t3_irr", irr_q, 8'h04);
        ir = 8'h00;
        step(3);
        check("t3_irr_drop", irr_q, 8'h00);
        check("t3_intreq_held", int_req, 1'b1);
        inta_seq(5'h08, 3'd7, 1'b0, 3'd0, "t3");
        check("t3_isr", isr_q, 8'h00);
        level_mode = 1'b0;
        step(2);

        // Non-specific EOI with rotation makes level 4 the lowest
        pulse_ir(8'h10);
        step(3);
        inta_seq(5'h08, 3'd4, 1'b0, 3'd0, "t4a");
        check("t4_isr10", isr_q, 8'h10);
        send_eoi(1'b0, 1'b1, 3'd0);
        check("t4_isr0", isr_q, 8'h00);
        pulse_ir(8'h50);
        step(3);
        inta_seq(5'h08, 3'd6, 1'b0, 3'd0, "t4b");
        step(3);
        check("t4_ir4_blocked", int_req, 1'b0);
        send_eoi(1'b0, 1'b0, 3'd0);
        step(3);
        check("t4_ir4_intreq", int_req, 1'b1);
        inta_seq(5'h08, 3'd4, 1'b0, 3'd0, "t4c");
        send_eoi(1'b0, 1'b0, 3'd0);
        set_pri(3'd7);
        check("t4_isr_clean", isr_q, 8'h00);

        // Specific EOI on level 2 in the same clock as ACK1 on level 2
        pulse_ir(8'h04);
        step(3);
        inta_seq(5'h08, 3'd2, 1'b1, 3'd2, "t5");
        check("t5_isr_ack_wins", isr_q, 8'h04);
        send_eoi(1'b1, 1'b0, 3'd2);
        check("t5_isr_clean", isr_q, 8'h00);

`ifdef AUTO_EOI_EN
        // Auto-EOI releases IR0 at ACK2
        auto_eoi = 1'b1;
        pulse_ir(8'h01);
        step(3);
        inta_seq(5'h08, 3'd0, 1'b0, 3'd0, "t6");
        check("t6_isr_auto", isr_q, 8'h00);
        auto_eoi = 1'b0;
        step(2);
`endif

        // Reset between ACK1 and ACK2
        pulse_ir(8'h08);
        step(3);
        inta_n = 1'b0;
        step(1);
        inta_n = 1'b1;
        step(1);
        check("t7_isr_mid", isr_q, 8'h08);
        reset_n = 1'b0;
        #2;
        check("t7_intreq", int_req, 1'b0);
        check("t7_vector", vector, 8'h00);
        check("t7_vvalid", vector_valid, 1'b0);
        check("t7_irr", irr_q, 8'h00);
        check("t7_isr", isr_q, 8'h00);
        check("t7_state", fsm_state, 2'd0);
        step(2);
        reset_n = 1'b1;
        step(1);
        inta_n = 1'b0;
        step(1);
        inta_n = 1'b1;
        check("t7_no_vvalid", vector_valid, 1'b0);
        check("t7_idle", fsm_state, 2'd0);
        step(1);
        check("t7_no_vvalid2", vector_valid, 1'b0);
        check("t7_no_intreq", int_req, 1'b0);

        // Random operations against the model (state is fresh after reset)
        m_irr     = 8'h00;
        m_isr     = 8'h00;
        m_imr     = 8'h00;
        m_lowest  = 7;
        m_pending = 1'b0;
        for (int it = 0; it < 250; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                bits = 8'($urandom_range(1, 255));
                if ($urandom_range(0, 1) == 1) bits = bits & 8'($urandom_range(0, 255));
                pulse_ir(bits);
                m_irr = m_irr | bits;
            end else if (op <= 6 && m_pending) begin
                c    = model_cand();
                base = 5'($urandom_range(0, 31));
                lvl  = (c >= 0) ? 3'(c) : 3'd7;
                inta_seq(base, lvl, 1'b0, 3'd0, "rnd");
                if (c >= 0) begin
                    m_isr[c] = 1'b1;
                    m_irr[c] = 1'b0;
                end
                m_pending = 1'b0;
            end else if (op <= 7 || op <= 6) begin
                spec = 1'($urandom_range(0, 1));
                rot  = 1'($urandom_range(0, 1));
                lvl  = 3'($urandom_range(0, 7));
                send_eoi(spec, rot, lvl);
                if (spec) begin
                    m_isr[lvl] = 1'b0;
                    if (rot) m_lowest = int'(lvl);
                end else begin
                    c = best_of(m_isr);
                    if (c >= 0) begin
                        m_isr[c] = 1'b0;
                        if (rot) m_lowest = c;
                    end
                end
            end else if (op == 8) begin
                lvl = 3'($urandom_range(0, 7));
                set_pri(lvl);
                m_lowest = int'(lvl);
            end else begin
                m_imr = 8'($urandom_range(0, 255) & $urandom_range(0, 255));
                imr   = m_imr;
                step(1);
            end
            step(3);
            if (model_cand() >= 0) m_pending = 1'b1;
            check("rnd_intreq", int_req, m_pending);
            check("rnd_irr", irr_q, m_irr);
            check("rnd_isr", isr_q, m_isr);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
